cnn_conv_stream: RTL and testbench



---
 rtl/cnn_pkg.sv | 14 +
 rtl/cnn_window_mac.sv | 44 ++++
 rtl/cnn_conv_stream.sv | 167 ++++++++++++++++
 tb/tb_cnn_conv_stream.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared state enum and size helpers for the streaming convolution engine
package cnn_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    function automatic int out_side(input int img, input int ks, input logic pad);
        return pad ? (img - ks + 3) : (img - ks + 1);
    endfunction

    function automatic int acc_width(input int data_w, input int ch, input int ks);
        return 2 * data_w + $clog2(ch * ks * ks);
    endfunction

endpackage

// File: rtl/cnn_window_mac.sv
// rtl/cnn_window_mac.sv - combinational CH*KS*KS window dot product with zero-padding mask
module cnn_window_mac #(
    parameter int DATA_W = 8,
    parameter int IMG    = 5,
    parameter int KS     = 2,
    parameter int CH     = 3,
    parameter int ACC_W  = 20,
    parameter int RC_W   = 3
) (
    input  logic [CH*IMG*IMG*DATA_W-1:0] img,
    input  logic [CH*KS*KS*DATA_W-1:0]   taps,
    input  logic [RC_W-1:0]              row,
    input  logic [RC_W-1:0]              col,
    input  logic                         pad,
    output logic [ACC_W-1:0]             sum
);

    always_comb begin
        logic signed [ACC_W-1:0]    acc;
        logic signed [2*DATA_W-1:0] prod;
        int y;
        int x;
        acc  = '0;
        prod = '0;
        y    = 0;
        x    = 0;
        for (int ch = 0; ch < CH; ch++) begin
            for (int kr = 0; kr < KS; kr++) begin
                for (int kc = 0; kc < KS; kc++) begin
                    y = int'(row) + kr - int'(pad);
                    x = int'(col) + kc - int'(pad);
                    // Taps that fall on the padding ring contribute nothing
                    if (y >= 0 && y < IMG && x >= 0 && x < IMG) begin
                        prod = (2*DATA_W)'($signed(img[((ch*IMG + y)*IMG + x)*DATA_W +: DATA_W]))
                             * (2*DATA_W)'($signed(taps[((ch*KS + kr)*KS + kc)*DATA_W +: DATA_W]));
                        acc  = acc + ACC_W'(prod);
                    end
                end
            end
        end
        sum = acc;
    end

endmodule

// File: rtl/cnn_conv_stream.sv
// rtl/cnn_conv_stream.sv - frame loader, output sequencer and ReLU register for the convolution engine
module cnn_conv_stream import cnn_pkg::*; #(
    parameter int  DATA_W = 8,
    parameter int  IMG    = 5,
    parameter int  KS     = 2,
    parameter int  CH     = 3,
    parameter int  KN     = 2,
    localparam int ACC_W  = acc_width(DATA_W, CH, KS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    Img,
    input  logic [KN*DATA_W-1:0] Kernel,
    input  logic [1:0]           Opt,
    output logic                 out_valid,
    output logic [ACC_W-1:0]     out
);

    localparam int TOTAL = CH * IMG * IMG;
    localparam int KT    = CH * KS * KS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int RC_W  = $clog2(IMG + 3);
    localparam int K_W   = (KN > 1) ? $clog2(KN) : 1;
    localparam int O_NP  = out_side(IMG, KS, 1'b0);
    localparam int O_P   = out_side(IMG, KS, 1'b1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         opt_q, opt_d;
    logic               act_q, act_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [RC_W-1:0]    r_q, r_d, c_q, c_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_q, out_d;

    logic [TOTAL*DATA_W-1:0]   img_q;
    logic [KN*KT*DATA_W-1:0]   ker_q;
    logic [KT*DATA_W-1:0]      taps;
    logic [ACC_W-1:0]          mac;
    logic [CNT_W-1:0]          wr_idx;
    logic [RC_W-1:0]           o_last;
    logic                      capture, issue, last_pix;

    assign capture  = in_valid && (state_q == IDLE || state_q == LOAD);
    assign wr_idx   = (state_q == IDLE) ? '0 : cnt_q;
    // RUN spends its first cycle arming act_q so the first result lands two edges after the last sample
    assign issue    = (state_q == RUN) && act_q;
    assign o_last   = opt_q[0] ? RC_W'(O_P - 1) : RC_W'(O_NP - 1);
    assign last_pix = (k_q == K_W'(KN - 1)) && (r_q == o_last) && (c_q == o_last);
    assign taps     = ker_q[int'(k_q)*KT*DATA_W +: KT*DATA_W];

    cnn_window_mac #(
        .DATA_W (DATA_W),
        .IMG    (IMG),
        .KS     (KS),
        .CH     (CH),
        .ACC_W  (ACC_W),
        .RC_W   (RC_W)
    ) u_mac (
        .img  (img_q),
        .taps (taps),
        .row  (r_q),
        .col  (c_q),
        .pad  (opt_q[0]),
        .sum  (mac)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opt_d       = opt_q;
        act_d       = 1'b0;
        k_d         = k_q;
        r_d         = r_q;
        c_d         = c_q;
        out_valid_d = issue;
        out_d       = '0;
        if (issue) begin
            out_d = (opt_q[1] && mac[ACC_W-1]) ? '0 : mac;
        end
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opt_d   = Opt;
                    cnt_d   = CNT_W'(1);
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = (TOTAL == 1) ? RUN : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TOTAL - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                act_d = 1'b1;
                if (issue) begin
                    if (last_pix) begin
                        state_d = IDLE;
                        act_d   = 1'b0;
                        cnt_d   = '0;
                        k_d     = '0;
                        r_d     = '0;
                        c_d     = '0;
                    end else if (c_q == o_last) begin
                        c_d = '0;
                        if (r_q == o_last) begin
                            r_d = '0;
                            k_d = k_q + K_W'(1);
                        end else begin
                            r_d = r_q + RC_W'(1);
                        end
                    end else begin
                        c_d = c_q + RC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opt_q       <= '0;
            act_q       <= 1'b0;
            k_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opt_q       <= opt_d;
            act_q       <= act_d;
            k_q         <= k_d;
            r_q         <= r_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Frame buffers carry no reset; every location is rewritten before RUN reads it
    always_ff @(posedge clk) begin
        if (capture) begin
            img_q[int'(wr_idx)*DATA_W +: DATA_W] <= Img;
            if (int'(wr_idx) < KT) begin
                for (int k = 0; k < KN; k++) begin
                    ker_q[(k*KT + int'(wr_idx))*DATA_W +: DATA_W] <= Kernel[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_cnn_conv_stream.sv
// tb/tb_cnn_conv_stream.sv - table-driven scoreboard bench for cnn_conv_stream
module tb_cnn_conv_stream;

    localparam int DATA_W = 8;
    localparam int IMG    = 5;
    localparam int KS     = 2;
    localparam int CH     = 3;
    localparam int KN     = 2;
    localparam int ACC_W  = 20;
    localparam int TOTAL  = CH * IMG * IMG;
    localparam int KT     = CH * KS * KS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [DATA_W-1:0]    Img = '0;
    logic [KN*DATA_W-1:0] Kernel = '0;
    logic [1:0]           Opt = '0;
    logic                 out_valid;
    logic [ACC_W-1:0]     out;

    cnn_conv_stream #(
        .DATA_W (DATA_W),
        .IMG    (IMG),
        .KS     (KS),
        .CH     (CH),
        .KN     (KN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Img       (Img),
        .Kernel    (Kernel),
        .Opt       (Opt),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        int       img_v;
        int       t0;
        int       t1;
        bit       rnd;
        logic [1:0] opt;
        int       exp_n;
        bit       chk_first;
        int       exp_first;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int img_arr[TOTAL];
    int ker_arr[KN][KT];
    int n_seen = 0;
    int first_out = 0;
    int zero_viol = 0;
    int got;
    int want;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, actual, required);
        end
    endtask

    function automatic int conv(input int k, input int r, input int c, input int pad);
        int s = 0;
        for (int ch = 0; ch < CH; ch++)
            for (int kr = 0; kr < KS; kr++)
                for (int kc = 0; kc < KS; kc++) begin
                    int y = r + kr - pad;
                    int x = c + kc - pad;
                    if (y >= 0 && y < IMG && x >= 0 && x < IMG)
                        s += img_arr[ch*IMG*IMG + y*IMG + x] * ker_arr[k][ch*KS*KS + kr*KS + kc];
                end
        return s;
    endfunction

    // Scoreboard: every result on the output stream is checked against the queue head
    always @(negedge clk) begin
        if (out_valid) begin
            got = int'($signed(out));
            n_seen++;
            if (n_seen == 1) first_out = got;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got=%0d want=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    errors++;
                    $display("FAIL result_%0d got=%0d want=%0d", n_seen, got, want);
                end
            end
        end else if (out != '0) begin
            zero_viol++;
        end
    end

    task automatic load_frame(input int iv, input int t0, input int t1, input bit rnd, input logic [1:0] opt);
        logic [KN*DATA_W-1:0] kv;
        int o;
        int pad;
        pad = int'(opt[0]);
        o   = pad ? (IMG - KS + 3) : (IMG - KS + 1);
        for (int i = 0; i < TOTAL; i++)
            img_arr[i] = rnd ? (int'($urandom_range(255)) - 128) : iv;
        for (int k = 0; k < KN; k++)
            for (int t = 0; t < KT; t++)
                ker_arr[k][t] = rnd ? (int'($urandom_range(255)) - 128) : ((k == 0) ? t0 : t1);
        for (int k = 0; k < KN; k++)
            for (int r = 0; r < o; r++)
                for (int c = 0; c < o; c++) begin
                    int s = conv(k, r, c, pad);
                    if (opt[1] && s < 0) s = 0;
                    exp_q.push_back(s);
                end
        n_seen = 0;
        for (int i = 0; i < TOTAL; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            Img      = DATA_W'(img_arr[i]);
            for (int k = 0; k < KN; k++)
                kv[k*DATA_W +: DATA_W] = (i < KT) ? DATA_W'(ker_arr[k][i]) : DATA_W'($urandom);
            Kernel = kv;
            Opt    = (i == 0) ? opt : 2'($urandom);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Img      = DATA_W'($urandom);
        Kernel   = KN*DATA_W'($urandom);
        Opt      = 2'($urandom);
    endtask

    task automatic check_frame(input string name, input int exp_n, input bit chk_first, input int exp_first);
        int lat = 0;
        int hi = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, 2);
        while (out_valid && hi < 200) begin
            hi++;
            @(posedge clk);
            #1;
        end
        check({name, "_valid_len"}, hi, exp_n);
        if (chk_first) check({name, "_first"}, first_out, exp_first);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"ones_nopad",    1,    1,    1, 1'b0, 2'b00, 32, 1'b1, 12};
        vecs[1] = '{"ones_pad",      1,    1,    1, 1'b0, 2'b01, 72, 1'b1, 3};
        vecs[2] = '{"sign_norelu",   1,   -1,    1, 1'b0, 2'b00, 32, 1'b1, -12};
        vecs[3] = '{"sign_relu",     1,   -1,    1, 1'b0, 2'b10, 32, 1'b1, 0};
        vecs[4] = '{"max_neg",    -128, -128, -128, 1'b0, 2'b00, 32, 1'b1, 196608};
        vecs[5] = '{"rand_nopad",    0,    0,    0, 1'b1, 2'b00, 32, 1'b0, 0};
        vecs[6] = '{"rand_pad",      0,    0,    0, 1'b1, 2'b01, 72, 1'b0, 0};
        vecs[7] = '{"rand_pad_relu", 0,    0,    0, 1'b1, 2'b11, 72, 1'b0, 0};
        vecs[8] = '{"twos",          2,    1,    1, 1'b0, 2'b00, 32, 1'b1, 24};

        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out", int'(out), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frames run back to back: each load starts the cycle after out_valid falls
        for (int v = 0; v < 9; v++) begin
            load_frame(vecs[v].img_v, vecs[v].t0, vecs[v].t1, vecs[v].rnd, vecs[v].opt);
            check_frame(vecs[v].name, vecs[v].exp_n, vecs[v].chk_first, vecs[v].exp_first);
        end

        // Reset in the middle of the output stream
        load_frame(1, 1, 1, 1'b0, 2'b00);
        begin
            int w = 0;
            while (n_seen < 5 && w < 300) begin
                @(posedge clk);
                #1;
                w++;
            end
            check("midrun_reached_5", (n_seen >= 5) ? 1 : 0, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_valid", int'(out_valid), 0);
        check("midrun_reset_out", int'(out), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_frame(1, 1, 1, 1'b0, 2'b00);
        check_frame("after_reset", 32, 1'b1, 12);

        check("out_zero_when_idle", zero_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
